// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multi-cycle control FSM.
//   - state_t        : FSM state encoding
//   - OP_*           : primary opcode values (instr[31:26])
//   - EXT_*          : immediate extender modes driven on ext_op_o
//   - ALU_*          : ALU operation codes driven on alu_op_o
//   - SRCB_* / PCSRC_* : datapath mux encodings
//   - decode_next()  : state following S_DECODE for a given opcode
package mc_pkg;

    localparam int OP_WIDTH = 6;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_WB_R   = 4'd3,
        S_EXEC_I = 4'd4,
        S_WB_I   = 4'd5,
        S_ADDR   = 4'd6,
        S_MEM_RD = 4'd7,
        S_MEM_WR = 4'd8,
        S_WB_MEM = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [OP_WIDTH-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_WIDTH-1:0] OP_J     = 6'h02;
    localparam logic [OP_WIDTH-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_WIDTH-1:0] OP_BNE   = 6'h05;
    localparam logic [OP_WIDTH-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_WIDTH-1:0] OP_SLTI  = 6'h0A;
    localparam logic [OP_WIDTH-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OP_WIDTH-1:0] OP_ORI   = 6'h0D;
    localparam logic [OP_WIDTH-1:0] OP_LUI   = 6'h0F;
    localparam logic [OP_WIDTH-1:0] OP_LW    = 6'h23;
    localparam logic [OP_WIDTH-1:0] OP_SW    = 6'h2B;

    localparam logic [1:0] EXT_SIGN  = 2'd0;
    localparam logic [1:0] EXT_ZERO  = 2'd1;
    localparam logic [1:0] EXT_UPPER = 2'd2;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_FUNCT = 3'd2;
    localparam logic [2:0] ALU_AND   = 3'd3;
    localparam logic [2:0] ALU_OR    = 3'd4;
    localparam logic [2:0] ALU_SLT   = 3'd5;

    localparam logic [1:0] SRCB_RT      = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    // Unknown opcodes return to S_FETCH; the caller flags them as illegal.
    function automatic state_t decode_next(input logic [OP_WIDTH-1:0] op);
        case (op)
            OP_RTYPE:                                 decode_next = S_EXEC_R;
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: decode_next = S_EXEC_I;
            OP_LW, OP_SW:                             decode_next = S_ADDR;
            OP_BEQ, OP_BNE:                           decode_next = S_BRANCH;
            OP_J:                                     decode_next = S_JUMP;
            default:                                  decode_next = S_FETCH;
        endcase
    endfunction

endpackage

// File: rtl/mc_mem_wait.sv
// mc_mem_wait: wait-state counter and stall/timeout decision for the
// memory handshake of mc_ctrl_fsm.
//   clk_i       : clock
//   rst_i       : synchronous reset, active-low
//   active_i    : FSM is in a memory state (request is being held)
//   mem_ready_i : memory completes the current request this cycle
//   done_o      : request completes this cycle (active and ready)
//   timeout_o   : TO_MAX-th consecutive not-ready cycle; abort the access
// The counter is zero whenever the FSM is outside a memory state or has
// just left one, so every entry into a memory state starts from zero.
module mc_mem_wait #(
    parameter int TO_W   = 4,
    parameter int TO_MAX = 15
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic active_i,
    input  logic mem_ready_i,
    output logic done_o,
    output logic timeout_o
);

    logic [TO_W-1:0] cnt_q;
    logic [TO_W-1:0] cnt_d;

    always_comb begin
        done_o    = active_i && mem_ready_i;
        // Ready wins over timeout when both land on the same cycle.
        timeout_o = active_i && !mem_ready_i && (cnt_q == TO_W'(TO_MAX - 1));
        if (active_i && !mem_ready_i && !timeout_o) begin
            cnt_d = cnt_q + TO_W'(1);
        end else begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle control FSM sequencing fetch / decode / execute /
// memory / writeback for the shared-ALU, shared-memory datapath.
//   clk_i, rst_i        : clock, synchronous active-low reset
//   opcode_i            : instr[31:26], sampled only in S_DECODE
//   zero_i              : ALU zero flag, used in S_BRANCH
//   mem_ready_i         : memory completes current request this cycle
//   mem_req_o/mem_we_o  : memory request / write strobe
//   iord_o              : memory address select (0 PC, 1 ALUOut)
//   ir_write_o          : latch instruction register
//   pc_write_o/pc_src_o : PC write enable and PC source select
//   ext_op_o            : immediate extender mode (sign / zero / upper)
//   alu_src_a_o/_b_o    : ALU operand muxes
//   alu_op_o            : ALU operation
//   reg_dst_o, mem_to_reg_o, reg_write_o : register-file write controls
//   illegal_o, bus_err_o : one-cycle pulses (unknown opcode / memory timeout)
//
// Memory handshake: mem_req_o is high for every cycle of S_FETCH, S_MEM_RD
// and S_MEM_WR; a cycle with mem_req_o and mem_ready_i both high completes
// the transfer and the FSM advances. mem_ready_i is ignored in all other
// states. After TO_MAX not-ready cycles the access is dropped, the FSM
// returns to S_FETCH with no IR/PC/register write, and bus_err_o pulses.
module mc_ctrl_fsm
    import mc_pkg::*;
#(
    parameter int OP_W   = 6,
    parameter int TO_W   = 4,
    parameter int TO_MAX = 15
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [OP_W-1:0] opcode_i,
    input  logic            zero_i,
    input  logic            mem_ready_i,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic            iord_o,
    output logic            ir_write_o,
    output logic            pc_write_o,
    output logic [1:0]      pc_src_o,
    output logic [1:0]      ext_op_o,
    output logic            alu_src_a_o,
    output logic [1:0]      alu_src_b_o,
    output logic [2:0]      alu_op_o,
    output logic            reg_dst_o,
    output logic            mem_to_reg_o,
    output logic            reg_write_o,
    output logic            illegal_o,
    output logic            bus_err_o
);

    state_t          state_q, state_d;
    logic [OP_W-1:0] op_q, op_d;
    logic            illegal_q, illegal_d;
    logic            bus_err_q, bus_err_d;

    logic mem_active;
    logic mem_done;
    logic mem_timeout;

    assign mem_active = (state_q == S_FETCH) || (state_q == S_MEM_RD) ||
                        (state_q == S_MEM_WR);

    mc_mem_wait #(
        .TO_W   (TO_W),
        .TO_MAX (TO_MAX)
    ) u_mem_wait (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .active_i    (mem_active),
        .mem_ready_i (mem_ready_i),
        .done_o      (mem_done),
        .timeout_o   (mem_timeout)
    );

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q   <= S_FETCH;
            op_q      <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        illegal_d = 1'b0;
        bus_err_d = mem_timeout;
        case (state_q)
            S_FETCH: begin
                if (mem_done) begin
                    state_d = S_DECODE;
                end
                // On timeout the FSM simply stays in S_FETCH and retries.
            end
            S_DECODE: begin
                op_d      = opcode_i;
                state_d   = decode_next(opcode_i);
                illegal_d = (decode_next(opcode_i) == S_FETCH);
            end
            S_EXEC_R: state_d = S_WB_R;
            S_WB_R:   state_d = S_FETCH;
            S_EXEC_I: state_d = S_WB_I;
            S_WB_I:   state_d = S_FETCH;
            S_ADDR:   state_d = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (mem_done) begin
                    state_d = S_WB_MEM;
                end else if (mem_timeout) begin
                    state_d = S_FETCH;
                end
            end
            S_MEM_WR: begin
                if (mem_done || mem_timeout) begin
                    state_d = S_FETCH;
                end
            end
            S_WB_MEM: state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // Output decode
    always_comb begin
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        iord_o       = 1'b0;
        ir_write_o   = 1'b0;
        pc_write_o   = 1'b0;
        pc_src_o     = PCSRC_ALU;
        ext_op_o     = EXT_SIGN;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = SRCB_RT;
        alu_op_o     = ALU_ADD;
        reg_dst_o    = 1'b0;
        mem_to_reg_o = 1'b0;
        reg_write_o  = 1'b0;
        illegal_o    = illegal_q;
        bus_err_o    = bus_err_q;
        case (state_q)
            S_FETCH: begin
                mem_req_o   = 1'b1;
                alu_src_b_o = SRCB_FOUR;
                ir_write_o  = mem_done;
                pc_write_o  = mem_done;
            end
            S_DECODE: begin
                alu_src_b_o = SRCB_IMM_SH2;
            end
            S_EXEC_R: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRCB_RT;
                alu_op_o    = ALU_FUNCT;
            end
            S_WB_R: begin
                reg_dst_o   = 1'b1;
                reg_write_o = 1'b1;
            end
            S_EXEC_I: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRCB_IMM;
                case (op_q)
                    OP_SLTI: alu_op_o = ALU_SLT;
                    OP_ANDI: begin
                        ext_op_o = EXT_ZERO;
                        alu_op_o = ALU_AND;
                    end
                    OP_ORI: begin
                        ext_op_o = EXT_ZERO;
                        alu_op_o = ALU_OR;
                    end
                    // lui relies on rs = $0, so OR with the upper immediate.
                    OP_LUI: begin
                        ext_op_o = EXT_UPPER;
                        alu_op_o = ALU_OR;
                    end
                    default: ;
                endcase
            end
            S_WB_I: begin
                reg_write_o = 1'b1;
            end
            S_ADDR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRCB_IMM;
            end
            S_MEM_RD: begin
                mem_req_o = 1'b1;
                iord_o    = 1'b1;
            end
            S_MEM_WR: begin
                mem_req_o = 1'b1;
                iord_o    = 1'b1;
                mem_we_o  = 1'b1;
            end
            S_WB_MEM: begin
                mem_to_reg_o = 1'b1;
                reg_write_o  = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRCB_RT;
                alu_op_o    = ALU_SUB;
                pc_src_o    = PCSRC_ALUOUT;
                pc_write_o  = (op_q == OP_BNE) ? !zero_i : zero_i;
            end
            S_JUMP: begin
                pc_src_o   = PCSRC_JUMP;
                pc_write_o = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multi-cycle control FSM for the next CPU revision (single-cycle datapath refactored to shared ALU/memory).
- Sequences fetch/decode/execute/memory/writeback per instruction.
- Configures the immediate extender (sign/zero/upper) and datapath muxes.
- Stalls on a ready/request memory handshake.

Parameters:
- OP_W, 6, opcode field width
- TO_W, 4, width of memory-wait timeout counter
- TO_MAX, 15, wait cycles before bus-error abort

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-low
- opcode_i  in  6  instr[31:26]; sampled only in S_DECODE
- zero_i  in  1  ALU zero flag, valid in S_BRANCH
- mem_ready_i  in  1  memory completes current request this cycle
- mem_req_o  out  1  memory request; held until mem_ready_i
- mem_we_o  out  1  write strobe, valid with mem_req_o
- iord_o  out  1  0 = PC address, 1 = ALUOut address
- ir_write_o  out  1  latch instruction register
- pc_write_o  out  1  unconditional PC update
- pc_src_o  out  2  0 = ALU, 1 = ALUOut (branch), 2 = jump target
- ext_op_o  out  2  extender mode: 0 sign, 1 zero, 2 {imm,16'b0}
- alu_src_a_o  out  1  0 = PC, 1 = rs
- alu_src_b_o  out  2  0 = rt, 1 = const 4, 2 = ext imm, 3 = ext imm<<2
- alu_op_o  out  3  0 add, 1 sub, 2 R-funct, 3 and, 4 or, 5 slt
- reg_dst_o  out  1  0 = rt, 1 = rd
- mem_to_reg_o  out  1  0 = ALUOut, 1 = MDR
- reg_write_o  out  1  register-file write enable
- illegal_o  out  1  one-cycle pulse on unknown opcode
- bus_err_o  out  1  one-cycle pulse on memory timeout

Behaviour:
- All regs update on posedge clk_i. rst_i == 0 at an edge forces S_FETCH, op_q = 0, timeout counter = 0, pulses cleared. This applies mid-instruction too; no partial write may follow.
- Outputs are Moore-decoded from state and op_q. In reset state S_FETCH, only mem_req_o = 1, with alu_src_b_o = 1. All other outputs are 0.
- States and transitions:
  - S_FETCH: mem_req_o = 1, iord_o = 0, alu_src_a_o = 0, alu_src_b_o = 1, alu_op_o = add. On mem_ready_i: ir_write_o = 1, pc_write_o = 1, go S_DECODE. Else stay.
  - S_DECODE: op_q <= opcode_i. Computes branch target: alu_src_b_o = 3, ext_op_o = 0. Next state by opcode_i:
    - 0x00 -> S_EXEC_R
    - 0x08 / 0x0A / 0x0C / 0x0D / 0x0F -> S_EXEC_I
    - 0x23 / 0x2B -> S_ADDR
    - 0x04 / 0x05 -> S_BRANCH
    - 0x02 -> S_JUMP
    - other -> S_FETCH with illegal_o pulsed next cycle
  - S_EXEC_R: alu_src_a_o = 1, alu_src_b_o = 0, alu_op_o = 2 -> S_WB_R.
  - S_WB_R: reg_dst_o = 1, reg_write_o = 1 -> S_FETCH.
  - S_EXEC_I: alu_src_a_o = 1, alu_src_b_o = 2. By op_q:
    - addi: ext 0, add
    - slti: ext 0, slt
    - andi: ext 1, and
    - ori: ext 1, or
    - lui: ext 2, or (rs = $0 by encoding)
    - Then -> S_WB_I.
  - S_WB_I: reg_dst_o = 0, reg_write_o = 1 -> S_FETCH.
  - S_ADDR: alu_src_a_o = 1, alu_src_b_o = 2, ext 0, add. Goes to S_MEM_RD for lw, S_MEM_WR for sw.
  - S_MEM_RD / S_MEM_WR: mem_req_o = 1, iord_o = 1, mem_we_o = 1 only in S_MEM_WR. On mem_ready_i: S_MEM_RD -> S_WB_MEM, S_MEM_WR -> S_FETCH.
  - S_WB_MEM: mem_to_reg_o = 1, reg_write_o = 1, reg_dst_o = 0 -> S_FETCH.
  - S_BRANCH: alu_src_a_o = 1, alu_src_b_o = 0, sub, pc_src_o = 1. pc_write_o = zero_i for beq, !zero_i for bne -> S_FETCH.
  - S_JUMP: pc_src_o = 2, pc_write_o = 1 -> S_FETCH.
- Memory wait and timeout:
  - The timeout counter clears on entry to any memory state and increments each cycle without mem_ready_i.
  - Reaching TO_MAX without ready -> S_FETCH, bus_err_o pulse, no ir/pc/reg write.
  - mem_ready_i and timeout in the same cycle: ready wins.
  - mem_ready_i outside memory states is ignored.
- Latency (zero-wait memory), in cycles:
  - R-type: 4
  - I-type ALU: 4
  - lw: 5
  - sw: 4
  - beq/bne: 3
  - j: 3
- Memory stall adds exactly N cycles for N not-ready cycles.

Decomposition:
- Shared package mc_pkg holds:
  - state enum
  - opcode constants
  - EXT_SIGN / EXT_ZERO / EXT_UPPER
  - ALU op codes
  - ALUSrcB / PCSrc encodings
- The extender is upgraded separately to accept ext_op_o.
- One natural sub-module, mc_mem_wait, holds the timeout counter and the stall/timeout decision.

Test Plan:
- Reset low for 2 cycles, release; mem_ready_i = 1 always, opcode 0x00 -> states FETCH, DECODE, EXEC_R, WB_R. reg_write_o = 1 and reg_dst_o = 1 in cycle 4 only.
- ori (0x0D) then lui (0x0F) -> ext_op_o = 1 then 2 in S_EXEC_I. alu_src_b_o = 2. reg_write_o in S_WB_I.
- lw with mem_ready_i low 3 cycles in S_MEM_RD -> 8 total cycles. mem_req_o held 4 cycles with iord_o = 1. mem_to_reg_o = 1 in the last cycle.
- beq with zero_i = 1 -> pc_write_o = 1, pc_src_o = 1. bne with zero_i = 1 -> pc_write_o = 0. Each takes 3 cycles.
- Opcode 0x3F -> illegal_o pulses once. Back to S_FETCH, no reg_write_o asserted.
- Memory never ready in FETCH -> bus_err_o pulses after TO_MAX = 15 cycles, ir_write_o never set. Separately, rst_i low during S_MEM_WR -> next cycle S_FETCH, mem_we_o = 0.
